// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and sizing helpers for serial_adder
// Contents: FSM state enum, STEPS / counter-width functions, configuration check.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    // Number of digit steps needed to cover the full operand width.
    function automatic int sa_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Step counter width; at least one bit so STEPS=1 still has a counter.
    function automatic int sa_cnt_w(input int width, input int digit);
        int steps;
        steps = width / digit;
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

    // Evaluated at elaboration by the top to reject WIDTH/DIGIT pairs that do not tile.
    function automatic bit sa_cfg_ok(input int width, input int digit);
        return (width >= 1) && (digit >= 1) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/sa_digit_adder.sv
// rtl/sa_digit_adder.sv - DIGIT-bit combinational ripple of full-adder cells
// Ports: a_d/b_d digit operands, c_in carry into bit 0, s_d digit sum,
//        c_out carry out of the top bit, c_msb_in carry into the top bit.
module sa_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [DIGIT:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        logic p;
        assign p          = a_d[i] ^ b_d[i];
        assign s_d[i]     = p ^ carry[i];
        assign carry[i+1] = (a_d[i] & b_d[i]) | (carry[i] & p);
    end

    assign c_out    = carry[DIGIT];
    // Carry into the top bit; XOR with c_out gives signed overflow.
    assign c_msb_in = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, DIGIT bits per clock, valid/ready in and out
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, a, b, cin operand side;
//        out_valid/out_ready, sum, cout result side; ovf when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = sa_steps(WIDTH, DIGIT);
    localparam int CNT_W = sa_cnt_w(WIDTH, DIGIT);

    if (!sa_cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    sa_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q;
    logic             accept, last_step;
    logic [DIGIT-1:0] s_d;
    logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             c_msb;
    logic             ovf_q;
`else
    logic             c_msb_unused;
`endif

    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q == CNT_W'(STEPS - 1));

    // Operands shift right each step, so the active digit is always the low DIGIT bits.
    sa_digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_d      (a_q[DIGIT-1:0]),
        .b_d      (b_q[DIGIT-1:0]),
        .c_in     (carry_q),
        .s_d      (s_d),
        .c_out    (c_out),
`ifdef SERIAL_ADDER_OVF_EN
        .c_msb_in (c_msb)
`else
        .c_msb_in (c_msb_unused)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            carry_q <= c_out;
            sum_q[int'(cnt_q)*DIGIT +: DIGIT] <= s_d;
            if (last_step) begin
                cnt_q  <= '0;
                cout_q <= c_out;
`ifdef SERIAL_ADDER_OVF_EN
                ovf_q  <= c_out ^ c_msb;
`endif
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random scoreboard bench for serial_adder (8/1 and 32/4)
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid8 = 1'b0, in_valid32 = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        in_ready8, out_valid8, cout8;
    logic [7:0]  sum8;
    logic        in_ready32, out_valid32, cout32;
    logic [31:0] sum32;
    logic        ovf8, ovf32;

    int n_cmp = 0;
    int n_err = 0;
    logic [33:0] sb[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder #(.WIDTH(32), .DIGIT(4)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid32), .out_ready(out_ready),
        .sum(sum32), .cout(cout32)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf32)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf8  = 1'b0;
    assign ovf32 = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit w);
        return w ? in_ready32 : in_ready8;
    endfunction

    function automatic logic vld(input bit w);
        return w ? out_valid32 : out_valid8;
    endfunction

    function automatic logic [32:0] res(input bit w);
        return w ? {cout32, sum32} : {24'b0, cout8, sum8};
    endfunction

    function automatic logic ovf_of(input bit w);
        return w ? ovf32 : ovf8;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {ovf, cout, sum} from an independent wide add.
    function automatic logic [33:0] model(input bit w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic cv);
        logic [32:0] r;
        logic        sa, sb_, ss, ov;
        if (w) begin
            r  = {1'b0, av} + {1'b0, bv} + {32'b0, cv};
            sa = av[31]; sb_ = bv[31]; ss = r[31];
        end else begin
            r  = {25'b0, av[7:0]} + {25'b0, bv[7:0]} + {32'b0, cv};
            sa = av[7]; sb_ = bv[7]; ss = r[7];
        end
        ov = (sa == sb_) && (ss != sa);
        return {ov, r};
    endfunction

    task automatic accept_op(input bit w, input logic [31:0] av, input logic [31:0] bv, input logic cv);
        a = av; b = bv; cin = cv;
        check("in_ready_idle", rdy(w), 1'b1);
        if (w) in_valid32 = 1'b1; else in_valid8 = 1'b1;
        sb.push_back(model(w, av, bv, cv));
        tick();
        in_valid8 = 1'b0; in_valid32 = 1'b0;
        a = $urandom; b = $urandom; cin = 1'(($urandom));
        check("in_ready_busy", rdy(w), 1'b0);
    endtask

    task automatic wait_result(input bit w, input int exp_lat);
        int lat;
        lat = 0;
        while (!vld(w) && lat < 100) begin
            tick();
            lat++;
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic handoff(input bit w);
        logic [33:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 34'h3_FFFF_FFFF;
        check("result", res(w), e[32:0]);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf_of(w), e[33]);
`endif
        check("in_ready_done", rdy(w), 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after", vld(w), 1'b0);
        check("in_ready_after", rdy(w), 1'b1);
    endtask

    task automatic do_op(input bit w, input logic [31:0] av, input logic [31:0] bv, input logic cv);
        accept_op(w, av, bv, cv);
        wait_result(w, w ? 8 : 8);
        handoff(w);
    endtask

    initial begin
        #12;
        check("rst_in_ready8", in_ready8, 1'b1);
        check("rst_out_valid8", out_valid8, 1'b0);
        check("rst_sum8", {cout8, sum8}, 9'h000);
        check("rst_in_ready32", in_ready32, 1'b1);
        check("rst_out_valid32", out_valid32, 1'b0);
        check("rst_sum32", {cout32, sum32}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op(1'b0, 32'h0F, 32'h01, 1'b0);
        do_op(1'b0, 32'hFF, 32'h01, 1'b1);
        check("dir_ff01", {cout8, sum8}, 9'h101);

        // Backpressure: result must hold while the producer keeps poking.
        accept_op(1'b0, 32'h3C, 32'h0A, 1'b0);
        wait_result(1'b0, 8);
        for (int i = 0; i < 5; i++) begin
            in_valid8 = ~in_valid8;
            a = $urandom;
            tick();
            check("bp_valid", out_valid8, 1'b1);
            check("bp_ready", in_ready8, 1'b0);
            check("bp_sum", {cout8, sum8}, 9'h046);
        end
        in_valid8 = 1'b0;
        handoff(1'b0);
        check("retain_sum", {cout8, sum8}, 9'h046);

        // Reset at RUN step 3 abandons the operation immediately.
        accept_op(1'b0, 32'h55, 32'h55, 1'b0);
        void'(sb.pop_back());
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_sum", {cout8, sum8}, 9'h000);
        check("rst_mid_valid", out_valid8, 1'b0);
        check("rst_mid_ready", in_ready8, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op(1'b0, 32'h22, 32'h11, 1'b0);

        do_op(1'b0, 32'h7F, 32'h01, 1'b0);
        do_op(1'b0, 32'h80, 32'h80, 1'b0);
        do_op(1'b0, 32'h05, 32'hFB, 1'b0);

        do_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        do_op(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            do_op(1'b1, $urandom, $urandom, 1'($urandom));
        end

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial successor to the gate-level full adder.
- Computes sum = a + b + cin over WIDTH bits, DIGIT bits per clock, using a registered carry between steps.
- Trades latency for area. Sits behind a valid/ready producer and in front of a valid/ready consumer in arithmetic datapaths.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be >= 1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH. STEPS = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  addend.
- b  in  WIDTH  addend.
- cin  in  1  carry in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, low WIDTH bits of a+b+cin.
- cout  out  1  carry out of bit WIDTH-1.

Behaviour:
- Reset is asynchronous, active-low; it is the only clock/reset behaviour, and there is one clock. On reset:
  - state=IDLE, step counter=0, carry register=0.
  - operand shift registers=0, sum=0, cout=0, out_valid=0, in_ready=1.
- FSM states: IDLE, RUN, DONE (encoding from package).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a, b, set carry register=cin, counter=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: digit i = counter processes bits [i*DIGIT +: DIGIT] through a DIGIT-bit ripple of full adders.
  - Write the result digit into sum[i*DIGIT +: DIGIT] and update the carry register.
  - Operand registers shift right by DIGIT, or are indexed; either is allowed.
  - After digit STEPS-1: cout = final carry, go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_valid&&out_ready go to IDLE. out_valid drops the next cycle; sum/cout retain their value until the next load.
- Latency:
  - out_valid rises exactly STEPS cycles after the accepting edge. Example: WIDTH=32, DIGIT=1 gives 32.
  - Throughput: one result per STEPS+2 cycles. No accept in the same cycle as result handoff.
- in_valid while in RUN/DONE: ignored; the producer must hold it.
- Operand inputs are sampled only on the accept edge; later changes have no effect.
- Counter width is max(1, $clog2(STEPS)). It wraps to 0 on the RUN->DONE transition.
- STEPS=1 (DIGIT=WIDTH): a single RUN cycle; same protocol applies.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned, all outputs go to reset values immediately, and no partial result is emitted.
- Arithmetic is unsigned modulo 2^WIDTH; cout carries the overflow bit.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (out, 1): signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - ovf is captured with cout, is valid with out_valid, and resets to 0.
- Undefined: no ovf port and no associated logic.

Decomposition:
- serial_adder_pkg holds:
  - the FSM state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a function computing STEPS and the counter width;
  - an elaboration-time check that WIDTH % DIGIT == 0.
- One combinational sub-module, sa_digit_adder: parameter DIGIT; ports a_d, b_d, c_in, s_d, c_out, c_msb_in.
  - Built as a chain of DIGIT full-adder cells (xor/and/or).
  - c_msb_in exposes the carry into the top bit for overflow detection.

Test Plan:
- WIDTH=8, DIGIT=1; a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0; out_valid high exactly 8 cycles after accept.
- WIDTH=8; a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1; in_ready low from accept until the cycle after handoff.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggle in_valid and a -> sum/cout stable, no new accept; release -> IDLE next cycle.
- Reset mid-operation: drop rst_n at RUN step 3 -> sum=0, out_valid=0, in_ready=1 asynchronously; a fresh a=0x22, b=0x11 -> sum=0x33.
- WIDTH=32, DIGIT=4: 1000 random a/b/cin, checked against a 33-bit model of a+b+cin -> all match; latency 8 cycles each.
- SERIAL_ADDER_OVF_EN, WIDTH=8:
  - a=0x7F, b=0x01 -> ovf=1, cout=0.
  - a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
  - a=0x05, b=0xFB -> ovf=0.
